// File: rtl/sensors_intf_sysid_checker.sv
// Avalon-MM master that reads the system-ID slave (ID, timestamp) after reset and issues a verdict.
// Define SYSID_CHECKER_TIMESTAMP_EN to make the timestamp compare part of the pass condition.
module sensors_intf_sysid_checker #(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1444878925,
   parameter int unsigned READ_LATENCY       = 0,
   parameter int unsigned STARTUP_DELAY      = 16,
   parameter int unsigned TIMEOUT_CYCLES     = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic [31:0] id_value,
   output logic [31:0] timestamp_value,
   output logic        check_done,
   output logic        check_pass,
   output logic        check_fail,
   output logic        timeout,
   output logic        sensors_enable
);

`ifdef SYSID_CHECKER_TIMESTAMP_EN
   localparam bit TS_EN = 1'b1;
`else
   localparam bit TS_EN = 1'b0;
`endif

   localparam logic [7:0]  DLY_LAST = 8'(STARTUP_DELAY - 1);
   localparam logic [1:0]  LAT_LAST = 2'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
   localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [15:0] TO_FULL  = 16'(TIMEOUT_CYCLES);
   localparam bit          NO_LAT   = (READ_LATENCY == 0);

   typedef enum logic [2:0] {
      S_DELAY, S_RD_ID, S_LAT_ID, S_RD_TS, S_LAT_TS, S_DONE
   } state_t;

   state_t      state_q;
   logic [7:0]  dly_q;
   logic [1:0]  lat_q;
   logic [15:0] stall_q;
   logic        read_q, addr_q;
   logic [31:0] id_q, ts_q;
   logic        done_q, pass_q, fail_q, timeout_q, en_q;

   logic        data_valid_d;
   logic        pass_d;

   // The ID is already captured when the timestamp arrives, so the verdict uses live read data.
   always_comb begin
      data_valid_d = 1'b0;
      if ((state_q == S_RD_ID || state_q == S_RD_TS) && !avm_waitrequest && NO_LAT)
         data_valid_d = 1'b1;
      if ((state_q == S_LAT_ID || state_q == S_LAT_TS) && lat_q == LAT_LAST)
         data_valid_d = 1'b1;
      pass_d = (id_q == EXPECTED_ID) && (!TS_EN || avm_readdata == EXPECTED_TIMESTAMP);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_DELAY;
         dly_q     <= '0;
         lat_q     <= '0;
         stall_q   <= '0;
         read_q    <= 1'b0;
         addr_q    <= 1'b0;
         id_q      <= '0;
         ts_q      <= '0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         fail_q    <= 1'b0;
         timeout_q <= 1'b0;
         en_q      <= 1'b0;
      end else begin
         case (state_q)
            S_DELAY: begin
               if (dly_q == DLY_LAST) begin
                  state_q <= S_RD_ID;
                  read_q  <= 1'b1;
                  addr_q  <= 1'b0;
                  stall_q <= '0;
               end else begin
                  dly_q <= dly_q + 8'd1;
               end
            end
            S_RD_ID, S_RD_TS: begin
               if (!avm_waitrequest) begin
                  stall_q <= '0;
                  if (!NO_LAT) begin
                     read_q  <= 1'b0;
                     lat_q   <= '0;
                     state_q <= (state_q == S_RD_ID) ? S_LAT_ID : S_LAT_TS;
                  end
               end else if (stall_q == TO_LAST) begin
                  // Give up: captured words keep their previous contents.
                  read_q    <= 1'b0;
                  stall_q   <= TO_FULL;
                  timeout_q <= 1'b1;
                  fail_q    <= 1'b1;
                  done_q    <= 1'b1;
                  state_q   <= S_DONE;
               end else begin
                  stall_q <= stall_q + 16'd1;
               end
            end
            S_LAT_ID, S_LAT_TS: begin
               if (!data_valid_d)
                  lat_q <= lat_q + 2'd1;
            end
            S_DONE: begin
               if (start) begin
                  done_q    <= 1'b0;
                  pass_q    <= 1'b0;
                  fail_q    <= 1'b0;
                  timeout_q <= 1'b0;
                  en_q      <= 1'b0;
                  state_q   <= S_RD_ID;
                  read_q    <= 1'b1;
                  addr_q    <= 1'b0;
                  stall_q   <= '0;
               end
            end
            default: state_q <= S_DELAY;
         endcase

         if (data_valid_d) begin
            if (state_q == S_RD_ID || state_q == S_LAT_ID) begin
               id_q    <= avm_readdata;
               state_q <= S_RD_TS;
               read_q  <= 1'b1;
               addr_q  <= 1'b1;
               stall_q <= '0;
            end else begin
               ts_q    <= avm_readdata;
               state_q <= S_DONE;
               read_q  <= 1'b0;
               done_q  <= 1'b1;
               pass_q  <= pass_d;
               fail_q  <= !pass_d;
               en_q    <= pass_d;
            end
         end
      end
   end

   assign avm_address     = addr_q;
   assign avm_read        = read_q;
   assign id_value        = id_q;
   assign timestamp_value = ts_q;
   assign check_done      = done_q;
   assign check_pass      = pass_q;
   assign check_fail      = fail_q;
   assign timeout         = timeout_q;
   assign sensors_enable  = en_q;

endmodule

// File: tb/tb_sensors_intf_sysid_checker.sv
// Directed bench for sensors_intf_sysid_checker: a zero-latency instance and a
// READ_LATENCY=2 instance with a stalling slave model.
module tb_sensors_intf_sysid_checker;

`ifdef SYSID_CHECKER_TIMESTAMP_EN
   localparam bit TS_EN = 1'b1;
`else
   localparam bit TS_EN = 1'b0;
`endif
   localparam logic [31:0] GOOD_TS = 32'd1444878925;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   int checks = 0;
   int errors = 0;

   // Instance 0: defaults, slave never stalls, zero latency
   logic        s0_start, a0_addr, a0_read, a0_wait;
   logic        a0_done, a0_pass, a0_fail, a0_to, a0_en;
   logic [31:0] a0_rdata, a0_id, a0_ts, id0_word, ts0_word;
   assign a0_wait  = 1'b0;
   assign a0_rdata = a0_addr ? ts0_word : id0_word;

   sensors_intf_sysid_checker u0 (
      .clock(clk), .reset(rst), .start(s0_start),
      .avm_address(a0_addr), .avm_read(a0_read), .avm_waitrequest(a0_wait),
      .avm_readdata(a0_rdata), .id_value(a0_id), .timestamp_value(a0_ts),
      .check_done(a0_done), .check_pass(a0_pass), .check_fail(a0_fail),
      .timeout(a0_to), .sensors_enable(a0_en)
   );

   // Instance 1: two-cycle read latency, configurable stalls per read
   logic        s1_start, a1_addr, a1_read, a1_wait;
   logic        a1_done, a1_pass, a1_fail, a1_to, a1_en;
   logic [31:0] a1_rdata, a1_id, a1_ts, id1_word, ts1_word;
   logic [31:0] p1a, p1b;
   int          nstall1, wcnt1;
   bit          stuck1;

   assign a1_wait  = a1_read && (stuck1 || (wcnt1 < nstall1));
   assign a1_rdata = p1b;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         wcnt1 <= 0;
         p1a   <= '0;
         p1b   <= '0;
      end else begin
         p1b <= p1a;
         if (a1_read && a1_wait) begin
            wcnt1 <= wcnt1 + 1;
         end else begin
            wcnt1 <= 0;
            if (a1_read) p1a <= a1_addr ? ts1_word : id1_word;
         end
      end
   end

   sensors_intf_sysid_checker #(
      .READ_LATENCY(2), .STARTUP_DELAY(4), .TIMEOUT_CYCLES(8)
   ) u1 (
      .clock(clk), .reset(rst), .start(s1_start),
      .avm_address(a1_addr), .avm_read(a1_read), .avm_waitrequest(a1_wait),
      .avm_readdata(a1_rdata), .id_value(a1_id), .timestamp_value(a1_ts),
      .check_done(a1_done), .check_pass(a1_pass), .check_fail(a1_fail),
      .timeout(a1_to), .sensors_enable(a1_en)
   );

   typedef struct {
      logic [31:0] id;
      logic [31:0] ts;
      logic        pass;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_zero(input string pfx);
      chk({pfx, "_u0_flags"}, 32'({a0_read, a0_addr, a0_done, a0_pass, a0_fail, a0_to, a0_en}), 32'd0);
      chk({pfx, "_u0_id"}, a0_id, 32'd0);
      chk({pfx, "_u0_ts"}, a0_ts, 32'd0);
      chk({pfx, "_u1_flags"}, 32'({a1_read, a1_addr, a1_done, a1_pass, a1_fail, a1_to, a1_en}), 32'd0);
      chk({pfx, "_u1_id"}, a1_id, 32'd0);
      chk({pfx, "_u1_ts"}, a1_ts, 32'd0);
   endtask

   // Counts edges after reset release; records first read and first verdict per instance.
   task automatic boot(input int budget, output int r0, output int d0, output int r1, output int d1);
      logic pw, pa;
      r0 = -1; d0 = -1; r1 = -1; d1 = -1;
      pw = 1'b0; pa = 1'b0;
      for (int c = 1; c <= budget; c++) begin
         @(posedge clk); #1;
         if (a0_read && r0 < 0) r0 = c;
         if (a0_done && d0 < 0) d0 = c;
         if (a1_read && r1 < 0) r1 = c;
         if (a1_done && d1 < 0) d1 = c;
         if (pw && a1_read) chk("addr_stable_in_stall", 32'(a1_addr), 32'(pa));
         pw = a1_read && a1_wait;
         pa = a1_addr;
      end
   endtask

   initial begin
      vec_t vecs [4];
      int   r0, d0, r1, d1, lat, hi;
      bit   seen;

      vecs[0] = '{32'd0,          GOOD_TS,         1'b1};
      vecs[1] = '{32'd0,          32'd1444878924,  !TS_EN};
      vecs[2] = '{32'd5,          GOOD_TS,         1'b0};
      vecs[3] = '{32'hFFFF_FFFF,  32'd0,           1'b0};

      rst = 1'b1; s0_start = 1'b0; s1_start = 1'b0;
      id0_word = 32'd0; ts0_word = GOOD_TS;
      id1_word = 32'd0; ts1_word = GOOD_TS;
      nstall1 = 3; stuck1 = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b0;

      // Power-up check: u0 no stalls, u1 latency 2 with 3 stalls per read
      boot(40, r0, d0, r1, d1);
      chk("u0_read_rise", 32'(r0), 32'd16);
      chk("u0_verdict_cycle", 32'(d0), 32'd18);
      chk("u0_flags", 32'({a0_pass, a0_en, a0_fail, a0_to}), 32'b1100);
      chk("u0_id", a0_id, 32'd0);
      chk("u0_ts", a0_ts, GOOD_TS);
      chk("u1_read_rise", 32'(r1), 32'd4);
      chk("u1_verdict_latency", 32'(d1 - r1), 32'd12);
      chk("u1_flags", 32'({a1_pass, a1_en, a1_fail, a1_to}), 32'b1100);
      chk("u1_id", a1_id, 32'd0);
      chk("u1_ts", a1_ts, GOOD_TS);
      $display("boot: u0 read@%0d verdict@%0d, u1 read@%0d verdict@%0d", r0, d0, r1, d1);

      // Table of re-checks on u0
      for (int i = 0; i < 4; i++) begin
         id0_word = vecs[i].id;
         ts0_word = vecs[i].ts;
         s0_start = 1'b1;
         @(posedge clk); #1;
         s0_start = 1'b0;
         chk("tbl_verdict_clear", 32'({a0_done, a0_pass, a0_fail, a0_en}), 32'd0);
         chk("tbl_read_addr", 32'({a0_read, a0_addr}), 32'b10);
         lat = -1;
         for (int c = 1; c <= 10 && lat < 0; c++) begin
            @(posedge clk); #1;
            if (a0_done) lat = c;
         end
         chk("tbl_latency", 32'(lat), 32'd2);
         chk("tbl_id", a0_id, vecs[i].id);
         chk("tbl_ts", a0_ts, vecs[i].ts);
         chk("tbl_verdict", 32'({a0_pass, a0_fail, a0_to, a0_en}),
             32'({vecs[i].pass, !vecs[i].pass, 1'b0, vecs[i].pass}));
         $display("vec %0d: id=0x%08h ts=%0d pass=%0b fail=%0b", i, a0_id, a0_ts, a0_pass, a0_fail);
      end
      id0_word = 32'd0;
      ts0_word = GOOD_TS;

      // u1 restart with ID 5; a start pulse during RD_TS must be ignored
      id1_word = 32'd5;
      s1_start = 1'b1;
      @(posedge clk); #1;
      s1_start = 1'b0;
      chk("u1_restart_clear", 32'({a1_done, a1_pass, a1_fail, a1_to, a1_en}), 32'd0);
      chk("u1_restart_read", 32'({a1_read, a1_addr}), 32'b10);
      seen = 1'b0;
      lat = -1;
      for (int c = 1; c <= 30 && lat < 0; c++) begin
         if (!seen && a1_read && a1_addr && a1_wait) begin
            s1_start = 1'b1;
            seen = 1'b1;
         end
         @(posedge clk); #1;
         s1_start = 1'b0;
         if (a1_done) lat = c;
      end
      chk("u1_start_in_rdts_applied", 32'(seen), 32'd1);
      chk("u1_restart_latency", 32'(lat), 32'd12);
      chk("u1_restart_id", a1_id, 32'd5);
      chk("u1_restart_verdict", 32'({a1_pass, a1_fail, a1_to, a1_en}), 32'b0100);
      repeat (3) @(posedge clk);
      #1;
      chk("u1_stays_done", 32'({a1_done, a1_read}), 32'b10);
      $display("restart: u1 id=%0d verdict latency %0d fail=%0b", a1_id, lat, a1_fail);

      // u1 timeout with waitrequest stuck high
      stuck1 = 1'b1;
      s1_start = 1'b1;
      @(posedge clk); #1;
      s1_start = 1'b0;
      hi = 0;
      for (int c = 0; c < 20 && a1_read; c++) begin
         hi++;
         @(posedge clk); #1;
      end
      chk("to_read_cycles", 32'(hi), 32'd8);
      chk("to_flags", 32'({a1_done, a1_pass, a1_fail, a1_to, a1_en}), 32'b10110);
      chk("to_addr", 32'(a1_addr), 32'd0);
      chk("to_id_kept", a1_id, 32'd5);
      chk("to_ts_kept", a1_ts, GOOD_TS);
      repeat (2) @(posedge clk);
      #1;
      chk("to_read_stays_low", 32'(a1_read), 32'd0);
      $display("timeout: read high %0d cycles, timeout=%0b", hi, a1_to);

      // Asynchronous reset while u1 sits in LAT_ID
      stuck1 = 1'b0;
      nstall1 = 0;
      id1_word = 32'd0;
      s1_start = 1'b1;
      @(posedge clk); #1;
      s1_start = 1'b0;
      @(posedge clk); #1;
      chk("u1_in_lat_id", 32'({a1_read, a1_addr, a1_done}), 32'd0);
      #2 rst = 1'b1;
      #1;
      check_zero("async_reset");
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      boot(40, r0, d0, r1, d1);
      chk("rerun_u0_read_rise", 32'(r0), 32'd16);
      chk("rerun_u0_verdict", 32'(d0), 32'd18);
      chk("rerun_u0_pass", 32'({a0_pass, a0_en, a0_fail}), 32'b110);
      chk("rerun_u1_read_rise", 32'(r1), 32'd4);
      chk("rerun_u1_verdict", 32'(d1), 32'd10);
      chk("rerun_u1_pass", 32'({a1_pass, a1_en, a1_fail}), 32'b110);
      chk("rerun_u1_id", a1_id, 32'd0);
      $display("rerun: u0 read@%0d verdict@%0d, u1 read@%0d verdict@%0d", r0, d0, r1, d1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
